// File: rtl/if_fetch.sv
// Instruction-fetch front end: issues in-order ROM requests under a 2-entry credit
// budget, buffers returned instructions with their PCs, and flushes on redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        jump_en,
  input  logic [31:0] npc,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_gnt,
  input  logic        irom_rvalid,
  input  logic [31:0] irom_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  logic [31:0] fetch_pc_r;
  logic [31:0] pcq_r [2];
  logic        pcq_wr_r;
  logic        pcq_rd_r;
  logic [1:0]  outstanding_r;
  logic [1:0]  drop_cnt_r;
  logic [31:0] fifo_pc_r [2];
  logic [31:0] fifo_inst_r [2];
  logic        fifo_wr_r;
  logic        fifo_rd_r;
  logic [1:0]  fifo_cnt_r;

  logic        pop_s;
  logic        grant_s;
  logic        resp_push_s;
  logic [2:0]  credit_s;

  // Credit check: in-flight requests plus buffered entries must leave a slot for every response.
  always_comb begin
    pop_s       = (fifo_cnt_r != 2'd0) && id_ready;
    credit_s    = {1'b0, outstanding_r} + {1'b0, fifo_cnt_r} - {2'b00, pop_s};
    irom_req    = !cpu_rst && !jump_en && (credit_s < 3'd2);
    grant_s     = irom_req && irom_gnt;
    resp_push_s = irom_rvalid && (drop_cnt_r == 2'd0);
  end

  assign irom_addr = fetch_pc_r;
  assign if_valid  = (fifo_cnt_r != 2'd0);
  assign if_pc     = fifo_pc_r[fifo_rd_r];
  assign if_inst   = fifo_inst_r[fifo_rd_r];

  // Fetch PC, request tracking, drop accounting and output buffer.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      fetch_pc_r    <= RESET_PC;
      pcq_wr_r      <= 1'b0;
      pcq_rd_r      <= 1'b0;
      outstanding_r <= 2'd0;
      drop_cnt_r    <= 2'd0;
      fifo_wr_r     <= 1'b0;
      fifo_rd_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else if (jump_en) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      fetch_pc_r    <= {npc[31:2], 2'b00};
      drop_cnt_r    <= outstanding_r - {1'b0, irom_rvalid};
      outstanding_r <= outstanding_r - {1'b0, irom_rvalid};
      if (irom_rvalid) begin
        pcq_rd_r <= ~pcq_rd_r;
      end
      fifo_wr_r  <= 1'b0;
      fifo_rd_r  <= 1'b0;
      fifo_cnt_r <= 2'd0;
    end else begin
      if (grant_s) begin
        pcq_r[pcq_wr_r] <= fetch_pc_r;
        pcq_wr_r        <= ~pcq_wr_r;
        fetch_pc_r      <= fetch_pc_r + 32'd4;
      end
      outstanding_r <= outstanding_r + {1'b0, grant_s} - {1'b0, irom_rvalid};
      if (irom_rvalid) begin
        pcq_rd_r <= ~pcq_rd_r;
        if (drop_cnt_r != 2'd0) begin
          drop_cnt_r <= drop_cnt_r - 2'd1;
        end
      end
      if (resp_push_s) begin
        fifo_pc_r[fifo_wr_r]   <= pcq_r[pcq_rd_r];
        fifo_inst_r[fifo_wr_r] <= irom_rdata;
        fifo_wr_r              <= ~fifo_wr_r;
      end
      if (pop_s) begin
        fifo_rd_r <= ~fifo_rd_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, resp_push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: queue-based reference model plus a fixed-latency in-order ROM,
// compared every cycle, with directed scenarios and literal spot checks.
module tb_if_fetch;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        jump_en;
  logic [31:0] npc;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_gnt;
  logic        irom_rvalid;
  logic [31:0] irom_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  if_fetch dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .jump_en(jump_en), .npc(npc),
    .irom_req(irom_req), .irom_addr(irom_addr), .irom_gnt(irom_gnt),
    .irom_rvalid(irom_rvalid), .irom_rdata(irom_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct { logic [31:0] pc; bit drop; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } rom_t;

  req_t        m_out[$];
  ent_t        m_fifo[$];
  rom_t        rom_q[$];
  logic [31:0] m_fpc;
  bit          m_valid, m_pop, m_req;
  int          cyc, lat;
  int          n_chk, n_fail;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // First half of a cycle: ROM drives its response, then outputs are compared with the model.
  task automatic pre();
    if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
      irom_rvalid = 1'b1;
      irom_rdata  = inst_of(rom_q[0].addr);
    end else begin
      irom_rvalid = 1'b0;
      irom_rdata  = $urandom;
    end
    #1;
    m_valid = (m_fifo.size() > 0);
    m_pop   = m_valid && id_ready;
    m_req   = !cpu_rst && !jump_en && ((m_out.size() + m_fifo.size() - (m_pop ? 1 : 0)) < 2);
    chk("irom_req", {31'd0, irom_req}, {31'd0, m_req});
    if (m_req) chk("irom_addr", irom_addr, m_fpc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_fifo[0].pc);
      chk("if_inst", if_inst, m_fifo[0].inst);
    end
  endtask

  // Second half: advance model and ROM by the rules, then cross the clock edge.
  task automatic post();
    req_t e;
    bit   got;
    got = 1'b0;
    if (cpu_rst) begin
      m_out.delete();
      m_fifo.delete();
      rom_q.delete();
      m_fpc = 32'h1C00_0000;
    end else begin
      if (irom_rvalid) begin
        void'(rom_q.pop_front());
        if (m_out.size() > 0) begin
          e   = m_out.pop_front();
          got = 1'b1;
        end
      end
      if (irom_req && irom_gnt) rom_q.push_back('{irom_addr, cyc + lat});
      if (jump_en) begin
        foreach (m_out[i]) m_out[i].drop = 1'b1;
        m_fifo.delete();
        m_fpc = {npc[31:2], 2'b00};
      end else begin
        if (m_pop) void'(m_fifo.pop_front());
        if (got && !e.drop) m_fifo.push_back('{e.pc, irom_rdata});
        if (m_req && irom_gnt) begin
          m_out.push_back('{m_fpc, 1'b0});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    @(posedge cpu_clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      pre();
      post();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; lat = 1;
    cpu_rst = 1'b1; jump_en = 1'b0; npc = 32'd0; irom_gnt = 1'b1;
    irom_rvalid = 1'b0; irom_rdata = 32'd0; id_ready = 1'b1;
    m_fpc = 32'h1C00_0000;
    @(posedge cpu_clk);
    #1;
    run(2);

    // Reset release with a 1-cycle ROM
    cpu_rst = 1'b0;
    pre(); chk("t1_req0", {31'd0, irom_req}, 32'd1); chk("t1_addr0", irom_addr, 32'h1C00_0000); post();
    pre(); chk("t1_addr1", irom_addr, 32'h1C00_0004); post();
    pre(); chk("t1_addr2", irom_addr, 32'h1C00_0008);
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc0", if_pc, 32'h1C00_0000); chk("t1_inst0", if_inst, 32'hE3FF_0000); post();
    pre(); chk("t1_pc1", if_pc, 32'h1C00_0004); post();
    run(3);
    irom_gnt = 1'b0; run(2); irom_gnt = 1'b1;
    run(5);

    // Backpressure straight out of reset
    cpu_rst = 1'b1; run(2);
    cpu_rst = 1'b0; id_ready = 1'b0;
    run(4);
    pre(); chk("t2_req_off", {31'd0, irom_req}, 32'd0);
    chk("t2_head_pc", if_pc, 32'h1C00_0000); post();
    id_ready = 1'b1;
    pre(); chk("t2_pc0", if_pc, 32'h1C00_0000); post();
    pre(); chk("t2_pc1", if_pc, 32'h1C00_0004); post();
    run(8);

    // Back-to-back redirects with two requests in flight on a 3-cycle ROM
    lat = 3;
    run(4);
    for (int k = 0; k < 20 && m_out.size() != 2; k++) run(1);
    if (m_out.size() != 2) timeout("t3_two_outstanding");
    jump_en = 1'b1; npc = 32'h1C00_0200; run(1);
    npc = 32'h1C00_0100; run(1);
    jump_en = 1'b0;
    for (int k = 0; k < 20 && m_fifo.size() == 0; k++) run(1);
    pre(); chk("t3_valid", {31'd0, if_valid}, 32'd1);
    chk("t3_pc", if_pc, 32'h1C00_0100); chk("t3_inst", if_inst, 32'hE3FF_0100); post();
    run(6);

    // Redirect coinciding with a response and a pop
    lat = 1;
    run(4);
    for (int k = 0; k < 20 && !(rom_q.size() > 0 && rom_q[0].due <= cyc && m_fifo.size() > 0); k++) run(1);
    if (!(rom_q.size() > 0 && rom_q[0].due <= cyc && m_fifo.size() > 0)) timeout("t4_align");
    jump_en = 1'b1; npc = 32'h1C00_0042;
    pre(); chk("t4_req_off", {31'd0, irom_req}, 32'd0); post();
    jump_en = 1'b0;
    pre(); chk("t4_req", {31'd0, irom_req}, 32'd1); chk("t4_addr", irom_addr, 32'h1C00_0040); post();
    run(6);

    // Reset mid-stream with buffer occupied
    lat = 3; id_ready = 1'b0;
    run(8);
    cpu_rst = 1'b1; run(1);
    pre(); chk("t5_valid", {31'd0, if_valid}, 32'd0); chk("t5_req", {31'd0, irom_req}, 32'd0); post();
    cpu_rst = 1'b0; id_ready = 1'b1; lat = 1;
    pre(); chk("t5_req_on", {31'd0, irom_req}, 32'd1); chk("t5_addr", irom_addr, 32'h1C00_0000); post();
    run(8);

    // Address wrap
    jump_en = 1'b1; npc = 32'hFFFF_FFFC;
    pre(); post();
    jump_en = 1'b0;
    pre(); chk("t6_req", {31'd0, irom_req}, 32'd1); chk("t6_addr0", irom_addr, 32'hFFFF_FFFC); post();
    pre(); chk("t6_addr1", irom_addr, 32'h0000_0000); post();
    pre(); chk("t6_pc0", if_pc, 32'hFFFF_FFFC); chk("t6_inst0", if_inst, 32'h0000_FFFC); post();
    pre(); chk("t6_pc1", if_pc, 32'h0000_0000); chk("t6_inst1", if_inst, 32'hFFFF_0000); post();
    run(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
